uart_rx_dma: RTL and testbench
==============================

UART_RX_DMA -- requirements
Module: uart_rx_dma

Interface
REQ-001 Parameter MAX_LENGTH, default 65535, maximum transfer length in bytes; LENGTH register width is $clog2(MAX_LENGTH+1).
REQ-002 i_clock  in  1  system clock; all logic on posedge.
REQ-003 i_reset  in  1  reset, synchronous, active-high.
REQ-004 i_request  in  1  CPU register-port request, held until o_ready.
REQ-005 i_rw  in  1  CPU port direction, 1=write.
REQ-006 i_address  in  2  register select: 0 BASE, 1 LENGTH, 2 CONTROL, 3 COUNT.
REQ-007 i_wdata  in  32  CPU write data.
REQ-008 o_rdata  out  32  CPU read data, registered.
REQ-009 o_ready  out  1  CPU access complete.
REQ-010 o_uart_request  out  1  request to UART receiver port.
REQ-011 o_uart_address  out  2  UART register select: 0 data byte, 1 status.
REQ-012 i_uart_rdata  in  32  UART read data; status bit1 = FIFO empty, data in bits 7:0.
REQ-013 i_uart_ready  in  1  UART access complete.
REQ-014 o_bus_request / o_bus_rw  out  1/1  memory write request, o_bus_rw always 1.
REQ-015 o_bus_address / o_bus_wdata  out  32/32  word address and packed data.
REQ-016 i_bus_ready  in  1  memory write complete.
REQ-017 o_interrupt  out  1  level interrupt: done AND irq_enable.

Function
REQ-018 CPU port: o_ready high from the cycle after i_request is sampled until i_request falls; write takes effect on the first o_ready cycle only.
REQ-019 BASE: read/write, bits 1:0 forced to 0; LENGTH: read/write; both ignored writes while busy.
REQ-020 CONTROL write: bit0 start (ignored if busy or LENGTH=0), bit1 abort, bit2 irq_enable; read: {29'b0, irq_enable, done, busy}.
REQ-021 COUNT read: bytes received in current/last transfer; any COUNT write clears done.
REQ-022 FSM states: IDLE, POLL, POLL_GAP, READ, READ_GAP, WRITE, DONE.
REQ-023 IDLE->POLL on start; start clears done, COUNT, byte lane, word pointer = BASE.
REQ-024 POLL: o_uart_request=1, address 1, until i_uart_ready; then POLL_GAP.
REQ-025 POLL_GAP: request low exactly one cycle (UART port rearms only on dropped request); FIFO empty -> POLL, else READ.
REQ-026 READ: address 0 until i_uart_ready; byte i_uart_rdata[7:0] placed in lane COUNT[1:0] (little-endian), COUNT+1; then READ_GAP (one idle cycle).
REQ-027 READ_GAP -> WRITE when lane 3 filled or COUNT==LENGTH; else POLL.
REQ-028 WRITE: o_bus_request until i_bus_ready; unfilled lanes of final partial word written as 0; word pointer +4; then DONE if COUNT==LENGTH else POLL.
REQ-029 DONE: sets done, clears busy, -> IDLE in one cycle.
REQ-030 Abort: in POLL/READ/WRITE completes the current handshake first, discards any partially filled word, then -> DONE; COUNT keeps received bytes.
REQ-031 Word pointer wraps modulo 2^32 without error.
REQ-032 Simultaneous COUNT write and DONE entry: done ends set.

Reset
REQ-033 Reset values: state IDLE, BASE 0, LENGTH 0, COUNT 0, irq_enable 0, done 0, all requests 0, o_rdata 0, o_ready 0, o_interrupt 0.
REQ-034 Reset mid-transfer drops all requests the next cycle; no partial memory write issued.

Structure
REQ-035 Package uart_dma_pkg holds FSM state enum, register address constants and CONTROL bit indices.
REQ-036 One sub-module, uart_dma_regs, implements the CPU register port; FSM and packing stay in top.

Verification
REQ-037 BASE=0x1000, LENGTH=4, bytes 11,22,33,44 -> one write 0x44332211 @0x1000, done=1, COUNT=4.
REQ-038 LENGTH=6, bytes 01..06 -> writes 0x04030201 @BASE, 0x00000605 @BASE+4.
REQ-039 FIFO empty 10 polls then byte -> o_uart_request low exactly one cycle between every UART access.
REQ-040 Abort after 2 bytes of LENGTH=8 -> no memory write, done=1, COUNT=2, busy=0.
REQ-041 irq_enable=1, transfer completes -> o_interrupt=1; COUNT write -> o_interrupt=0 next cycle.
REQ-042 Reset asserted during WRITE with i_bus_ready low -> o_bus_request=0 next cycle, CONTROL reads 0.

Source files
------------

// File: rtl/uart_dma_pkg.sv
// Shared definitions for the UART receive DMA block.
//   state_e        - transfer FSM states
//   ADDR_*         - CPU register-port address map
//   CTRL_*         - bit positions inside the CONTROL register
//   UART_ADDR_*    - UART receiver register select values
//   UART_STATUS_*  - bit positions inside the UART status word
package uart_dma_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_POLL,
        S_POLL_GAP,
        S_READ,
        S_READ_GAP,
        S_WRITE,
        S_DONE
    } state_e;

    localparam logic [1:0] ADDR_BASE    = 2'd0;
    localparam logic [1:0] ADDR_LENGTH  = 2'd1;
    localparam logic [1:0] ADDR_CONTROL = 2'd2;
    localparam logic [1:0] ADDR_COUNT   = 2'd3;

    localparam int CTRL_START  = 0;
    localparam int CTRL_ABORT  = 1;
    localparam int CTRL_IRQ_EN = 2;

    localparam logic [1:0] UART_ADDR_DATA   = 2'd0;
    localparam logic [1:0] UART_ADDR_STATUS = 2'd1;

    localparam int UART_STATUS_EMPTY = 1;

endpackage

// File: rtl/uart_rx_dma_if.sv
// Memory write port of the UART receive DMA.
//   o_bus_request - write request, held until i_bus_ready
//   o_bus_rw      - direction, always 1 (write)
//   o_bus_address - word address
//   o_bus_wdata   - packed little-endian data word
//   i_bus_ready   - write complete
// master: the DMA engine; slave: the memory.
interface uart_rx_dma_if;

    logic        o_bus_request;
    logic        o_bus_rw;
    logic [31:0] o_bus_address;
    logic [31:0] o_bus_wdata;
    logic        i_bus_ready;

    modport master (
        output o_bus_request,
        output o_bus_rw,
        output o_bus_address,
        output o_bus_wdata,
        input  i_bus_ready
    );

    modport slave (
        input  o_bus_request,
        input  o_bus_rw,
        input  o_bus_address,
        input  o_bus_wdata,
        output i_bus_ready
    );

endinterface

// File: rtl/uart_dma_regs.sv
// CPU register port of the UART receive DMA.
//   i_request/i_rw/i_address/i_wdata - CPU access, request held until o_ready
//   o_rdata/o_ready                  - registered read data and access complete
//   i_busy/i_done/i_count            - engine status shown in CONTROL and COUNT
//   o_base/o_length/o_irq_enable     - programmed configuration
//   o_start/o_abort/o_count_write    - single-cycle command strobes
// Each access is acted on once, on the edge where o_ready rises.
module uart_dma_regs
    import uart_dma_pkg::*;
#(
    parameter int LW = 16
) (
    input  logic          i_clock,
    input  logic          i_reset,
    input  logic          i_request,
    input  logic          i_rw,
    input  logic [1:0]    i_address,
    input  logic [31:0]   i_wdata,
    output logic [31:0]   o_rdata,
    output logic          o_ready,
    input  logic          i_busy,
    input  logic          i_done,
    input  logic [LW-1:0] i_count,
    output logic [31:0]   o_base,
    output logic [LW-1:0] o_length,
    output logic          o_irq_enable,
    output logic          o_start,
    output logic          o_abort,
    output logic          o_count_write
);

    logic [31:0]   base_q, base_d;
    logic [LW-1:0] length_q, length_d;
    logic          irq_enable_q, irq_enable_d;
    logic [31:0]   rdata_q, rdata_d;
    logic          ready_q, ready_d;
    logic          access;

    always_comb begin
        // NOTE: every output of this block is given a default first, so no path leaves one unassigned and no latch is inferred.
        base_d        = base_q;
        length_d      = length_q;
        irq_enable_d  = irq_enable_q;
        rdata_d       = rdata_q;
        ready_d       = i_request;
        o_start       = 1'b0;
        o_abort       = 1'b0;
        o_count_write = 1'b0;

        // A held request is serviced only on the cycle o_ready is still low.
        access = i_request && !ready_q;

        if (access && !i_rw) begin
            case (i_address)
                ADDR_BASE:    rdata_d = base_q;
                ADDR_LENGTH:  rdata_d = 32'(length_q);
                ADDR_CONTROL: rdata_d = {29'b0, irq_enable_q, i_done, i_busy};
                ADDR_COUNT:   rdata_d = 32'(i_count);
                default:      rdata_d = '0;
            endcase
        end

        if (access && i_rw) begin
            case (i_address)
                ADDR_BASE:    if (!i_busy) base_d = {i_wdata[31:2], 2'b00};
                ADDR_LENGTH:  if (!i_busy) length_d = i_wdata[LW-1:0];
                ADDR_CONTROL: begin
                    irq_enable_d = i_wdata[CTRL_IRQ_EN];
                    o_start      = i_wdata[CTRL_START] && !i_busy && (length_q != '0);
                    o_abort      = i_wdata[CTRL_ABORT];
                end
                ADDR_COUNT:   o_count_write = 1'b1;
                default:      ;
            endcase
        end
    end

    always_ff @(posedge i_clock) begin
        // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values regardless of statement order.
        if (i_reset) begin
            base_q       <= '0;
            length_q     <= '0;
            irq_enable_q <= 1'b0;
            rdata_q      <= '0;
            ready_q      <= 1'b0;
        end else begin
            base_q       <= base_d;
            length_q     <= length_d;
            irq_enable_q <= irq_enable_d;
            rdata_q      <= rdata_d;
            ready_q      <= ready_d;
        end
    end

    assign o_base       = base_q;
    assign o_length     = length_q;
    assign o_irq_enable = irq_enable_q;
    assign o_rdata      = rdata_q;
    assign o_ready      = ready_q;

endmodule

// File: rtl/uart_rx_dma.sv
// UART receive DMA: polls a UART receiver, packs received bytes little-endian
// into 32-bit words and writes them to consecutive memory words from BASE.
//   i_clock/i_reset            - clock, synchronous active-high reset
//   i_request..o_ready         - CPU register port (BASE, LENGTH, CONTROL, COUNT)
//   o_uart_request..i_uart_ready - UART receiver port (0 data, 1 status)
//   bus                        - memory write port
//   o_interrupt                - level interrupt, done AND irq_enable
module uart_rx_dma
    import uart_dma_pkg::*;
#(
    parameter int MAX_LENGTH = 65535
) (
    input  logic                i_clock,
    input  logic                i_reset,
    input  logic                i_request,
    input  logic                i_rw,
    input  logic [1:0]          i_address,
    input  logic [31:0]         i_wdata,
    output logic [31:0]         o_rdata,
    output logic                o_ready,
    output logic                o_uart_request,
    output logic [1:0]          o_uart_address,
    input  logic [31:0]         i_uart_rdata,
    input  logic                i_uart_ready,
    uart_rx_dma_if.master       bus,
    output logic                o_interrupt
);

    localparam int LW = $clog2(MAX_LENGTH + 1);

    state_e        state_q, state_d;
    logic [LW-1:0] count_q, count_d;
    logic [31:0]   word_q, word_d;
    logic [31:0]   ptr_q, ptr_d;
    logic          done_q, done_d;
    logic          abort_q, abort_d;
    logic          empty_q, empty_d;
    logic          uart_req_q, uart_req_d;
    logic [1:0]    uart_addr_q, uart_addr_d;
    logic          bus_req_q, bus_req_d;

    logic [31:0]   base;
    logic [LW-1:0] length;
    logic          irq_enable;
    logic          start_cmd, abort_cmd, count_write;
    logic          busy, last, word_full;
    logic          unused_uart_bits;

    assign busy             = (state_q != S_IDLE);
    assign last             = (count_q == length);
    // After a byte lands, a zero lane index means lane 3 was just filled.
    assign word_full        = (count_q[1:0] == 2'b00);
    assign unused_uart_bits = ^i_uart_rdata[31:8];

    uart_dma_regs #(.LW(LW)) u_regs (
        .i_clock       (i_clock),
        .i_reset       (i_reset),
        .i_request     (i_request),
        .i_rw          (i_rw),
        .i_address     (i_address),
        .i_wdata       (i_wdata),
        .o_rdata       (o_rdata),
        .o_ready       (o_ready),
        .i_busy        (busy),
        .i_done        (done_q),
        .i_count       (count_q),
        .o_base        (base),
        .o_length      (length),
        .o_irq_enable  (irq_enable),
        .o_start       (start_cmd),
        .o_abort       (abort_cmd),
        .o_count_write (count_write)
    );

    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        word_d      = word_q;
        ptr_d       = ptr_q;
        done_d      = done_q;
        abort_d     = abort_q;
        empty_d     = empty_q;
        uart_req_d  = uart_req_q;
        uart_addr_d = uart_addr_q;
        bus_req_d   = bus_req_q;

        if (count_write) done_d = 1'b0;
        // Abort is remembered and acted on at the next handshake boundary.
        if (abort_cmd && busy) abort_d = 1'b1;

        case (state_q)
            S_IDLE: begin
                if (start_cmd) begin
                    state_d     = S_POLL;
                    count_d     = '0;
                    word_d      = '0;
                    ptr_d       = base;
                    done_d      = 1'b0;
                    abort_d     = 1'b0;
                    uart_req_d  = 1'b1;
                    uart_addr_d = UART_ADDR_STATUS;
                end
            end
            S_POLL: begin
                if (i_uart_ready) begin
                    uart_req_d = 1'b0;
                    empty_d    = i_uart_rdata[UART_STATUS_EMPTY];
                    state_d    = S_POLL_GAP;
                end
            end
            // The UART port only rearms after seeing its request drop for a cycle.
            S_POLL_GAP: begin
                if (abort_q) begin
                    state_d = S_DONE;
                end else begin
                    uart_req_d  = 1'b1;
                    uart_addr_d = empty_q ? UART_ADDR_STATUS : UART_ADDR_DATA;
                    state_d     = empty_q ? S_POLL : S_READ;
                end
            end
            S_READ: begin
                if (i_uart_ready) begin
                    uart_req_d                           = 1'b0;
                    word_d[{count_q[1:0], 3'b000} +: 8] = i_uart_rdata[7:0];
                    count_d                              = count_q + LW'(1);
                    state_d                              = S_READ_GAP;
                end
            end
            // A completed word is still written on abort; only a partial one is dropped.
            S_READ_GAP: begin
                if (word_full || last) begin
                    bus_req_d = 1'b1;
                    state_d   = S_WRITE;
                end else if (abort_q) begin
                    state_d = S_DONE;
                end else begin
                    uart_req_d  = 1'b1;
                    uart_addr_d = UART_ADDR_STATUS;
                    state_d     = S_POLL;
                end
            end
            S_WRITE: begin
                if (bus.i_bus_ready) begin
                    bus_req_d = 1'b0;
                    ptr_d     = ptr_q + 32'd4;
                    word_d    = '0;
                    if (abort_q || last) begin
                        state_d = S_DONE;
                    end else begin
                        uart_req_d  = 1'b1;
                        uart_addr_d = UART_ADDR_STATUS;
                        state_d     = S_POLL;
                    end
                end
            end
            // Setting done here overrides a COUNT write landing in the same cycle.
            S_DONE: begin
                done_d  = 1'b1;
                abort_d = 1'b0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state_q     <= S_IDLE;
            count_q     <= '0;
            word_q      <= '0;
            ptr_q       <= '0;
            done_q      <= 1'b0;
            abort_q     <= 1'b0;
            empty_q     <= 1'b0;
            uart_req_q  <= 1'b0;
            uart_addr_q <= UART_ADDR_DATA;
            bus_req_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            word_q      <= word_d;
            ptr_q       <= ptr_d;
            done_q      <= done_d;
            abort_q     <= abort_d;
            empty_q     <= empty_d;
            uart_req_q  <= uart_req_d;
            uart_addr_q <= uart_addr_d;
            bus_req_q   <= bus_req_d;
        end
    end

    assign o_uart_request    = uart_req_q;
    assign o_uart_address    = uart_addr_q;
    assign bus.o_bus_request = bus_req_q;
    assign bus.o_bus_rw      = 1'b1;
    assign bus.o_bus_address = ptr_q;
    assign bus.o_bus_wdata   = word_q;
    assign o_interrupt       = done_q & irq_enable;

endmodule

// File: tb/tb_uart_rx_dma.sv
// Self-checking bench for uart_rx_dma: directed transfers driven through the
// CPU port, a UART receiver model fed from a byte queue, a memory slave, and
// one monitor comparing every memory write against an expected-write list
// derived from BASE, LENGTH and the byte stream.
module tb_uart_rx_dma;

    localparam logic [1:0] A_BASE = 2'd0, A_LENGTH = 2'd1, A_CONTROL = 2'd2, A_COUNT = 2'd3;

    logic        clk;
    logic        i_reset;
    logic        i_request, i_rw;
    logic [1:0]  i_address;
    logic [31:0] i_wdata, o_rdata;
    logic        o_ready;
    logic        o_uart_request;
    logic [1:0]  o_uart_address;
    logic [31:0] i_uart_rdata;
    logic        i_uart_ready;
    logic        o_interrupt;

    uart_rx_dma_if bus_if ();

    uart_rx_dma dut (
        .i_clock        (clk),
        .i_reset        (i_reset),
        .i_request      (i_request),
        .i_rw           (i_rw),
        .i_address      (i_address),
        .i_wdata        (i_wdata),
        .o_rdata        (o_rdata),
        .o_ready        (o_ready),
        .o_uart_request (o_uart_request),
        .o_uart_address (o_uart_address),
        .i_uart_rdata   (i_uart_rdata),
        .i_uart_ready   (i_uart_ready),
        .bus            (bus_if),
        .o_interrupt    (o_interrupt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic [7:0]  stim[$];
    logic [7:0]  uart_q[$];
    logic [31:0] exp_addr[$];
    logic [31:0] exp_data[$];
    int          empty_left    = 0;
    int          status_reads  = 0;
    int          uart_lat      = 0;
    int          bus_lat       = 0;
    bit          bus_hold      = 1'b0;
    bit          gap_en        = 1'b0;
    bit          gap_seen      = 1'b0;
    int          gap_low       = 0;
    int          gaps          = 0;
    logic        irq_at_ack;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h required %h", name, act, req);
        end
    endtask

    task automatic flag(input string name, input logic [31:0] act);
        total++;
        bad++;
        $display("FAIL %s: got %h required none", name, act);
    endtask

    // Expected writes: one per 4-byte group, little-endian, missing lanes zero,
    // addresses stepping by 4 modulo 2^32. The bytes also feed the UART model.
    task automatic model_load(input logic [31:0] base, input int len);
        logic [31:0] w;
        for (int i = 0; i < len; i += 4) begin
            w = '0;
            for (int j = 0; j < 4; j++)
                if (i + j < len) w = w | (32'(stim[i+j]) << (8 * j));
            exp_addr.push_back(base + 32'(i));
            exp_data.push_back(w);
        end
        foreach (stim[k]) uart_q.push_back(stim[k]);
    endtask

    task automatic cpu_access(input logic rw, input logic [1:0] a, input logic [31:0] d,
                              output logic [31:0] r);
        int n;
        @(negedge clk);
        i_request = 1'b1; i_rw = rw; i_address = a; i_wdata = d;
        n = 0;
        do begin @(negedge clk); n++; end while (!o_ready && n < 50);
        if (!o_ready) flag("cpu_ready_timeout", 32'(o_ready));
        r          = o_rdata;
        irq_at_ack = o_interrupt;
        i_request  = 1'b0;
        n = 0;
        while (o_ready && n < 50) begin @(negedge clk); n++; end
        i_rw = 1'b0;
    endtask

    task automatic cpu_write(input logic [1:0] a, input logic [31:0] d);
        logic [31:0] r;
        cpu_access(1'b1, a, d, r);
    endtask

    task automatic cpu_read(input logic [1:0] a, output logic [31:0] r);
        cpu_access(1'b0, a, 32'h0, r);
    endtask

    task automatic wait_idle();
        logic [31:0] r;
        int n = 0;
        do begin cpu_read(A_CONTROL, r); n++; end while (r[0] && n < 400);
        if (r[0]) flag("busy_timeout", r);
    endtask

    task automatic run_transfer(input string tag, input logic [31:0] base, input int len);
        logic [31:0] r;
        cpu_write(A_BASE, base);
        cpu_write(A_LENGTH, 32'(len));
        model_load(base, len);
        cpu_write(A_CONTROL, 32'h1);
        wait_idle();
        cpu_read(A_CONTROL, r);
        check({tag, "_control"}, r, 32'h2);
        cpu_read(A_COUNT, r);
        check({tag, "_count"}, r, 32'(len));
        check({tag, "_writes_left"}, 32'(exp_addr.size()), 32'h0);
    endtask

    // UART receiver model: status bit1 reports empty while forced-empty polls
    // remain or the byte queue is drained; upper bits carry filler to expose misuse.
    initial begin
        i_uart_ready = 1'b0;
        i_uart_rdata = '0;
        forever begin
            @(negedge clk);
            if (o_uart_request === 1'b1 && !i_uart_ready && !i_reset) begin
                repeat (uart_lat) @(negedge clk);
                if (o_uart_address == 2'd1) begin
                    status_reads++;
                    if (empty_left > 0 || uart_q.size() == 0) begin
                        i_uart_rdata = 32'h0000_0002;
                        if (empty_left > 0) empty_left--;
                    end else begin
                        i_uart_rdata = 32'hFFFF_FFFD;
                    end
                end else if (uart_q.size() > 0) begin
                    i_uart_rdata = {24'hABCDEF, uart_q.pop_front()};
                end else begin
                    i_uart_rdata = 32'hABCDEFEE;
                end
                i_uart_ready = 1'b1;
                @(negedge clk);
                i_uart_ready = 1'b0;
            end
        end
    end

    initial begin
        bus_if.i_bus_ready = 1'b0;
        forever begin
            @(negedge clk);
            if (bus_if.o_bus_request === 1'b1 && !bus_if.i_bus_ready && !bus_hold && !i_reset) begin
                repeat (bus_lat) @(negedge clk);
                bus_if.i_bus_ready = 1'b1;
                @(negedge clk);
                bus_if.i_bus_ready = 1'b0;
            end
        end
    end

    // Compare process: memory writes against the expected list, write direction,
    // and UART request gaps when enabled.
    always @(negedge clk) begin
        #1;
        if (!i_reset) begin
            if (bus_if.o_bus_request === 1'b1) check("bus_rw", 32'(bus_if.o_bus_rw), 32'h1);
            if (bus_if.o_bus_request === 1'b1 && bus_if.i_bus_ready) begin
                if (exp_addr.size() == 0) begin
                    flag("bus_write_unexpected", bus_if.o_bus_address);
                end else begin
                    check("bus_addr", bus_if.o_bus_address, exp_addr.pop_front());
                    check("bus_data", bus_if.o_bus_wdata, exp_data.pop_front());
                end
            end
            if (o_uart_request === 1'b1) begin
                if (gap_en && gap_seen && gap_low > 0) begin
                    check("uart_gap", 32'(gap_low), 32'h1);
                    gaps++;
                end
                gap_low  = 0;
                gap_seen = 1'b1;
            end else if (gap_seen) begin
                gap_low++;
            end
        end
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] r;
        int n;
        i_reset = 1'b1; i_request = 1'b0; i_rw = 1'b0; i_address = '0; i_wdata = '0;
        repeat (3) @(negedge clk);
        i_reset = 1'b0;

        // Reset state.
        check("rst_rdata", o_rdata, 32'h0);
        check("rst_ready", 32'(o_ready), 32'h0);
        check("rst_irq", 32'(o_interrupt), 32'h0);
        check("rst_uart_req", 32'(o_uart_request), 32'h0);
        check("rst_bus_req", 32'(bus_if.o_bus_request), 32'h0);
        cpu_read(A_BASE, r);    check("rst_base", r, 32'h0);
        cpu_read(A_LENGTH, r);  check("rst_length", r, 32'h0);
        cpu_read(A_CONTROL, r); check("rst_control", r, 32'h0);
        cpu_read(A_COUNT, r);   check("rst_count", r, 32'h0);

        // BASE drops its two low bits.
        cpu_write(A_BASE, 32'h0000_1003);
        cpu_read(A_BASE, r); check("base_align", r, 32'h0000_1000);

        // Four bytes -> one word.
        stim = '{8'h11, 8'h22, 8'h33, 8'h44};
        model_load(32'h0, 0);
        stim.delete();
        stim = '{8'h11, 8'h22, 8'h33, 8'h44};
        cpu_write(A_BASE, 32'h1000);
        cpu_write(A_LENGTH, 32'd4);
        model_load(32'h1000, 4);
        check("model_w0_data", exp_data[0], 32'h4433_2211);
        check("model_w0_addr", exp_addr[0], 32'h0000_1000);
        uart_q.delete(); exp_addr.delete(); exp_data.delete();
        run_transfer("t4", 32'h1000, 4);

        // Six bytes -> full word then zero-padded partial word.
        stim = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
        uart_lat = 1; bus_lat = 2;
        cpu_write(A_BASE, 32'h2000);
        cpu_write(A_LENGTH, 32'd6);
        model_load(32'h2000, 6);
        check("model_w1_data", exp_data[1], 32'h0000_0605);
        check("model_w1_addr", exp_addr[1], 32'h0000_2004);
        uart_q.delete(); exp_addr.delete(); exp_data.delete();
        run_transfer("t6", 32'h2000, 6);

        // Ten empty polls then one byte: request low exactly one cycle between accesses.
        stim = '{8'h5A};
        uart_lat = 0; bus_lat = 0;
        empty_left = 10; status_reads = 0;
        gap_seen = 1'b0; gap_low = 0; gaps = 0; gap_en = 1'b1;
        run_transfer("t_poll", 32'h3000, 1);
        gap_en = 1'b0;
        check("poll_status_reads", 32'(status_reads), 32'd11);
        check("poll_gap_count", 32'(gaps), 32'd11);

        // Word pointer wraps past 2^32.
        stim = '{8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5, 8'hA6, 8'hA7, 8'hA8};
        bus_lat = 1;
        run_transfer("t_wrap", 32'hFFFF_FFFC, 8);

        // Abort after two of eight bytes; configuration writes ignored while busy.
        stim = '{8'hB1, 8'hB2};
        uart_q.push_back(8'hB1); uart_q.push_back(8'hB2);
        cpu_write(A_BASE, 32'h4000);
        cpu_write(A_LENGTH, 32'd8);
        cpu_write(A_CONTROL, 32'h1);
        n = 0;
        do begin cpu_read(A_COUNT, r); n++; end while (r != 32'd2 && n < 200);
        check("abort_count_reached", r, 32'd2);
        cpu_read(A_CONTROL, r); check("abort_busy_before", 32'(r[0]), 32'h1);
        cpu_write(A_LENGTH, 32'd3);
        cpu_write(A_BASE, 32'h9990);
        cpu_read(A_LENGTH, r); check("busy_length_kept", r, 32'd8);
        cpu_read(A_BASE, r);   check("busy_base_kept", r, 32'h4000);
        cpu_write(A_CONTROL, 32'h2);
        wait_idle();
        cpu_read(A_CONTROL, r); check("abort_control", r, 32'h2);
        cpu_read(A_COUNT, r);   check("abort_count", r, 32'd2);

        // COUNT write clears done; start with LENGTH=0 is ignored.
        cpu_write(A_COUNT, 32'h0);
        cpu_write(A_LENGTH, 32'h0);
        cpu_write(A_CONTROL, 32'h1);
        repeat (5) @(negedge clk);
        check("len0_no_uart", 32'(o_uart_request), 32'h0);
        cpu_read(A_CONTROL, r); check("len0_control", r, 32'h0);

        // Interrupt follows done AND irq_enable; a COUNT write drops it.
        stim = '{8'hC1, 8'hC2};
        cpu_write(A_BASE, 32'h5000);
        cpu_write(A_LENGTH, 32'd2);
        model_load(32'h5000, 2);
        cpu_write(A_CONTROL, 32'h5);
        wait_idle();
        check("irq_writes_left", 32'(exp_addr.size()), 32'h0);
        check("irq_high", 32'(o_interrupt), 32'h1);
        cpu_read(A_CONTROL, r); check("irq_control", r, 32'h6);
        cpu_write(A_COUNT, 32'h0);
        check("irq_low_after_count_wr", 32'(irq_at_ack), 32'h0);
        cpu_read(A_CONTROL, r); check("irq_control_cleared", r, 32'h4);

        // Reset while a memory write is stalled.
        stim = '{8'hD1, 8'hD2, 8'hD3, 8'hD4};
        foreach (stim[k]) uart_q.push_back(stim[k]);
        bus_hold = 1'b1;
        cpu_write(A_BASE, 32'h6000);
        cpu_write(A_LENGTH, 32'd4);
        cpu_write(A_CONTROL, 32'h5);
        n = 0;
        while (bus_if.o_bus_request !== 1'b1 && n < 300) begin @(negedge clk); n++; end
        check("stall_bus_req", 32'(bus_if.o_bus_request), 32'h1);
        i_reset = 1'b1;
        @(posedge clk); #1;
        check("reset_bus_req", 32'(bus_if.o_bus_request), 32'h0);
        check("reset_uart_req", 32'(o_uart_request), 32'h0);
        @(negedge clk);
        i_reset = 1'b0;
        bus_hold = 1'b0;
        uart_q.delete();
        cpu_read(A_CONTROL, r); check("reset_control", r, 32'h0);
        cpu_read(A_BASE, r);    check("reset_base", r, 32'h0);
        check("reset_irq", 32'(o_interrupt), 32'h0);
        repeat (5) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
